// File: rtl/orsram_bank_ctrl.sv
// Bank of single-port SRAMs with a zero-fill clear engine and per-bank read pipelines.
// Bank traffic is accepted only in READY; requests during a clear are reported on req_drop.
module orsram_bank_ctrl #(
    parameter int unsigned NUM_BANK = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 7,
    parameter bit          OUT_REG  = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr_start,
    output logic                         busy,
    input  logic [NUM_BANK-1:0]          req,
    input  logic [NUM_BANK-1:0]          we,
    input  logic [NUM_BANK*ADDR_W-1:0]   addr,
    input  logic [NUM_BANK*DATA_W-1:0]   wdata,
    output logic [NUM_BANK-1:0]          rvalid,
    output logic [NUM_BANK*DATA_W-1:0]   rdata,
    output logic [NUM_BANK-1:0]          req_drop
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_n;
            clr_cnt <= clr_cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        clr_cnt_n = clr_cnt;
        busy      = (state == CLEAR);
        case (state)
            CLEAR: begin
                if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                    state_n   = READY;
                    clr_cnt_n = '0;
                end else begin
                    clr_cnt_n = clr_cnt + ADDR_W'(1);
                end
            end
            READY: begin
                if (clr_start) state_n = CLEAR;
            end
            default: state_n = CLEAR;
        endcase
    end

    for (genvar i = 0; i < int'(NUM_BANK); i++) begin : g_bank
        logic [DATA_W-1:0] mem [DEPTH];
        logic [ADDR_W-1:0] bank_addr;
        logic [DATA_W-1:0] bank_wdata;
        logic              rd_en, wr_en;
        logic              valid_q;
        logic [DATA_W-1:0] data_q;
        logic              drop_q;

        assign bank_addr  = addr[(i+1)*ADDR_W-1 -: ADDR_W];
        assign bank_wdata = wdata[(i+1)*DATA_W-1 -: DATA_W];
        assign rd_en      = (state == READY) && req[i] && !we[i];
        assign wr_en      = (state == READY) && req[i] && we[i];

        always_ff @(posedge clk) begin
            if (state == CLEAR) begin
                mem[clr_cnt] <= '0;
            end else if (wr_en) begin
                mem[bank_addr] <= bank_wdata;
            end
        end

        // Read data is captured at the issue edge, so a clear starting later cannot corrupt it.
        if (OUT_REG) begin : g_oreg
            logic              v1;
            logic [DATA_W-1:0] d1;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v1      <= 1'b0;
                    d1      <= '0;
                    valid_q <= 1'b0;
                    data_q  <= '0;
                end else begin
                    v1      <= rd_en;
                    valid_q <= v1;
                    if (rd_en) d1     <= mem[bank_addr];
                    if (v1)    data_q <= d1;
                end
            end
        end else begin : g_noreg
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                end else begin
                    valid_q <= rd_en;
                    if (rd_en) data_q <= mem[bank_addr];
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) drop_q <= 1'b0;
            else     drop_q <= (state == CLEAR) && req[i];
        end

        assign rvalid[i]                      = valid_q;
        assign rdata[(i+1)*DATA_W-1 -: DATA_W] = data_q;
        assign req_drop[i]                    = drop_q;
    end

endmodule
